dram_pad_rd_assembler: RTL and testbench
========================================

Name: dram_pad_rd_assembler

Overview:
- Downstream consumer of the pad counter logic: the read-data assembler on the DRAM pad side.
- Each cycle it writes the pad-sampled DQ beats into a 4-slot staging array, indexed by pad_pos_cnt.
- On each pad data-valid pulse it packs the two just-completed slots into one word and pushes it into a small FIFO.
- The DRAM controller drains the FIFO through a valid/ready handshake; a sticky overflow flag reports drops.

Parameters:
- DQ_WIDTH, 16, bits per pad edge (dq_pos and dq_neg each).
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2.
- PTR_W, 2, log2(FIFO_DEPTH); count width is PTR_W+1.

Ports:
- clk  in  1  core clock, the same clock that drives the pad counter.
- arst_l  in  1  reset; asynchronous assert, active low.
- pad_pos_cnt  in  2  pos-edge beat counter from the pad logic.
- pad_data_valid  in  1  registered data-valid from the pad logic; high the cycle after pad_pos_cnt was 1 or 3.
- cap_en  in  1  capture enable (read burst in progress).
- dq_pos  in  DQ_WIDTH  DQ sampled on the rising pad edge, already retimed to clk.
- dq_neg  in  DQ_WIDTH  DQ sampled on the falling pad edge, already retimed to clk.
- fifo_clr  in  1  synchronous flush: empties the FIFO and clears ovf.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  4*DQ_WIDTH  head entry.
- fifo_cnt  out  PTR_W+1  current occupancy, 0..FIFO_DEPTH.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (arst_l=0, any time including mid-burst):
  - Staging slots, FIFO storage, pointers, cap_en_q and ovf all go to 0.
  - Outputs read rd_valid=0, fifo_cnt=0, ovf=0, rd_data=0.
- Staging write:
  - On each clk edge with cap_en=1, slot[pad_pos_cnt] <= {dq_neg, dq_pos}.
  - With cap_en=0, slots hold their values.
- cap_en_q:
  - cap_en registered once. It qualifies the push so that the final pair of a burst is still pushed after cap_en drops.
- Push condition: push = pad_data_valid & cap_en_q.
- Pair select at push: sel = ~pad_pos_cnt[1].
  - sel=0 uses slots 0,1; sel=1 uses slots 2,3.
  - The counter has already advanced to 2 or 0 when pad_data_valid is high.
- Entry format: {slot[2*sel+1], slot[2*sel]}.
  - rd_data[DQ_WIDTH-1:0] = dq_pos of the even beat.
  - rd_data[4*DQ_WIDTH-1:3*DQ_WIDTH] = dq_neg of the odd beat.
- Latency:
  - Odd slot written at the end of cycle t.
  - Push at the end of t+1.
  - rd_valid=1 and data visible in t+2.
- Pop: pop = rd_valid & rd_ready.
  - rd_data is driven combinationally from the head storage entry.
  - rd_data holds stable while rd_valid=1 and rd_ready=0.
- Occupancy:
  - fifo_cnt increments on push-only and decrements on pop-only.
  - It is unchanged when push and pop happen together, or when neither happens.
- Full (fifo_cnt==FIFO_DEPTH):
  - Push without pop: entry dropped, pointers unchanged, ovf set to 1.
  - Push with pop in the same cycle: both are accepted, no overflow, count stays FIFO_DEPTH.
- Empty: rd_valid=0. rd_ready is ignored, and pointers and count do not change.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH.
- ovf: once set, it stays 1 until fifo_clr or reset.
- fifo_clr:
  - Takes priority over same-cycle push and pop; both are discarded.
  - Next cycle: fifo_cnt=0, rd_valid=0, ovf=0.
  - Staging slots are not cleared.
- Stale slots: a push with cap_en_q=1 whose slots were not written this burst uses the held values. This is allowed; software guarantees bursts are aligned to pad_pos_cnt=0.

Test Plan:
1. Reset, then single 4-beat burst: cap_en=1 for cnt 0..3 with dq_pos=0x1000+cnt and dq_neg=0x2000+cnt, rd_ready=1 -> two pops.
   - First: rd_data=0x2001_1001_2000_1000.
   - Second: 0x2003_1003_2002_1002.
   - rd_valid rises 2 cycles after cnt=1.
2. Back-pressure and overflow: rd_ready=0 across 3 bursts (6 pushes, DEPTH=4) -> fifo_cnt saturates at 4, ovf=1.
   - Then drain: exactly 4 entries pop, in order, from the first two bursts.
3. Simultaneous push and pop at full: fill to 4, assert rd_ready=1 in the push cycle -> cnt stays 4, ovf stays 0, no entry lost.
4. fifo_clr with a push in the same cycle: cnt=3 plus push and fifo_clr -> next cycle cnt=0, rd_valid=0, ovf=0, pushed data discarded.
5. cap_en drops right after the cnt=3 beat -> the final pair is still pushed via cap_en_q.
   - With cap_en held 0 for a whole cycle of cnt 0..3, no pushes occur.
6. Async reset mid-burst: assert arst_l low with cnt=2 and 2 entries queued -> rd_valid=0, fifo_cnt=0, ovf=0 immediately, without waiting for a clock edge.
   - After release, a fresh burst reproduces the scenario 1 data.

Source files
------------

// File: rtl/dram_pad_rd_assembler_if.sv
// Bundle between the pad-side capture logic, the read-data assembler and the
// DRAM controller that drains assembled read words.
interface dram_pad_rd_assembler_if #(
    parameter int DQ_WIDTH = 16,
    parameter int PTR_W    = 2
);
    logic [1:0]            pad_pos_cnt;
    logic                  pad_data_valid;
    logic                  cap_en;
    logic [DQ_WIDTH-1:0]   dq_pos;
    logic [DQ_WIDTH-1:0]   dq_neg;
    logic                  fifo_clr;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [4*DQ_WIDTH-1:0] rd_data;
    logic [PTR_W:0]        fifo_cnt;
    logic                  ovf;

    modport master (
        output pad_pos_cnt, pad_data_valid, cap_en, dq_pos, dq_neg, fifo_clr, rd_ready,
        input  rd_valid, rd_data, fifo_cnt, ovf
    );

    modport slave (
        input  pad_pos_cnt, pad_data_valid, cap_en, dq_pos, dq_neg, fifo_clr, rd_ready,
        output rd_valid, rd_data, fifo_cnt, ovf
    );
endinterface

// File: rtl/dram_pad_rd_assembler.sv
// DRAM pad read-data assembler: stages DQ beats in four slots, packs completed
// beat pairs into words and queues them in a small FIFO with sticky overflow.
module dram_pad_rd_assembler #(
    parameter int DQ_WIDTH   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                     clk,
    input  logic                     arst_l,
    dram_pad_rd_assembler_if.slave   bus
);
    localparam int SLOT_W  = 2 * DQ_WIDTH;
    localparam int ENTRY_W = 4 * DQ_WIDTH;
    localparam logic [PTR_W-1:0] PTR_INC = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_INC = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [SLOT_W-1:0]  slot_r [4];
    logic [ENTRY_W-1:0] fifo_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W:0]     cnt_r;
    logic               cap_en_q_r;
    logic               ovf_r;

    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               wr_en_s;
    logic               drop_s;
    logic [ENTRY_W-1:0] entry_s;

    function automatic logic [ENTRY_W-1:0] pack_pair(input logic [SLOT_W-1:0] odd_slot,
                                                     input logic [SLOT_W-1:0] even_slot);
        return {odd_slot, even_slot};
    endfunction

    // Push/pop qualification; the pad counter has already moved past the pair at push time.
    always_comb begin
        push_s  = bus.pad_data_valid & cap_en_q_r;
        pop_s   = (cnt_r != {(PTR_W+1){1'b0}}) & bus.rd_ready;
        full_s  = (cnt_r == CNT_FULL);
        wr_en_s = push_s & (~full_s | pop_s);
        drop_s  = push_s & full_s & ~pop_s;
        if (bus.pad_pos_cnt[1] == 1'b0) begin
            entry_s = pack_pair(slot_r[3], slot_r[2]);
        end else begin
            entry_s = pack_pair(slot_r[1], slot_r[0]);
        end
    end

    // Beat staging slots and the delayed capture enable.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < 4; i++) slot_r[i] <= '0;
            cap_en_q_r <= 1'b0;
        end else begin
            if (bus.cap_en) slot_r[bus.pad_pos_cnt] <= {bus.dq_neg, bus.dq_pos};
            cap_en_q_r <= bus.cap_en;
        end
    end

    // FIFO storage; a flush discards any same-cycle push.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= '0;
        end else if (!bus.fifo_clr && wr_en_s) begin
            fifo_r[wr_ptr_r] <= entry_s;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            ovf_r    <= 1'b0;
        end else if (bus.fifo_clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_INC;
            if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_INC;
            case ({wr_en_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_INC;
                2'b01:   cnt_r <= cnt_r - CNT_INC;
                default: cnt_r <= cnt_r;
            endcase
            if (drop_s) ovf_r <= 1'b1;
        end
    end

    assign bus.rd_valid = (cnt_r != {(PTR_W+1){1'b0}});
    assign bus.rd_data  = fifo_r[rd_ptr_r];
    assign bus.fifo_cnt = cnt_r;
    assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_dram_pad_rd_assembler.sv
// Directed bench for dram_pad_rd_assembler: queue-based reference model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_dram_pad_rd_assembler;
    localparam int DQW   = 16;
    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic clk = 1'b0;
    logic arst_l;
    always #5 clk = ~clk;

    dram_pad_rd_assembler_if #(.DQ_WIDTH(DQW), .PTR_W(PW)) bus ();

    dram_pad_rd_assembler #(.DQ_WIDTH(DQW), .FIFO_DEPTH(DEPTH), .PTR_W(PW)) dut (
        .clk    (clk),
        .arst_l (arst_l),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [1:0]  cnt;
    logic [15:0] pos_base;
    logic [15:0] neg_base;

    // reference model state
    logic [63:0] mq [$];
    logic [63:0] mlog [$];
    logic [31:0] mslot [4];
    logic        mceq;
    logic        movf;
    logic [63:0] m_word;
    logic        m_full;
    logic        m_pop;
    logic        m_push;
    int          m_base;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model advances on what the DUT sampled at the edge, then outputs are compared.
    always begin
        @(posedge clk);
        #1;
        if (!arst_l) begin
            mq.delete();
            foreach (mslot[i]) mslot[i] = 32'h0;
            mceq = 1'b0;
            movf = 1'b0;
            check("reset_rd_data", bus.rd_data, 64'h0);
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() > 0) && bus.rd_ready;
            m_push = bus.pad_data_valid && mceq;
            // counter at 2 means beats 0,1 just completed; otherwise beats 2,3
            m_base = (bus.pad_pos_cnt < 2'd2) ? 2 : 0;
            m_word = {mslot[m_base+1], mslot[m_base]};
            if (bus.fifo_clr) begin
                mq.delete();
                movf = 1'b0;
            end else begin
                if (m_pop) begin
                    mlog.push_back(mq[0]);
                    void'(mq.pop_front());
                end
                if (m_push) begin
                    if (m_full && !m_pop) movf = 1'b1;
                    else mq.push_back(m_word);
                end
            end
            if (bus.cap_en) mslot[bus.pad_pos_cnt] = {bus.dq_neg, bus.dq_pos};
            mceq = bus.cap_en;
        end
        check("model_rd_valid", {63'h0, bus.rd_valid}, (mq.size() != 0) ? 64'h1 : 64'h0);
        check("model_fifo_cnt", {61'h0, bus.fifo_cnt}, 64'(mq.size()));
        check("model_ovf", {63'h0, bus.ovf}, {63'h0, movf});
        if (mq.size() != 0) check("model_rd_data", bus.rd_data, mq[0]);
    end

    task automatic cyc(input logic ce, input logic rr, input logic clr);
        @(negedge clk);
        bus.pad_data_valid = (cnt == 2'd1) || (cnt == 2'd3);
        cnt = cnt + 2'd1;
        bus.pad_pos_cnt = cnt;
        bus.cap_en      = ce;
        bus.dq_pos      = pos_base + {14'd0, cnt};
        bus.dq_neg      = neg_base + {14'd0, cnt};
        bus.rd_ready    = rr;
        bus.fifo_clr    = clr;
    endtask

    task automatic burst(input logic rr);
        while (cnt != 2'd3) cyc(1'b0, rr, 1'b0);
        repeat (4) cyc(1'b1, rr, 1'b0);
    endtask

    task automatic run_basic();
        pos_base = 16'h1000;
        neg_base = 16'h2000;
        while (cnt != 2'd3) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("basic_valid_cnt2", {63'h0, bus.rd_valid}, 64'h0);
        cyc(1'b1, 1'b1, 1'b0);
        check("basic_valid_cnt3", {63'h0, bus.rd_valid}, 64'h1);
        check("basic_data0", bus.rd_data, 64'h2001_1001_2000_1000);
        cyc(1'b0, 1'b1, 1'b0);
        check("basic_gap", {63'h0, bus.rd_valid}, 64'h0);
        cyc(1'b0, 1'b1, 1'b0);
        check("basic_valid_pair1", {63'h0, bus.rd_valid}, 64'h1);
        check("basic_data1", bus.rd_data, 64'h2003_1003_2002_1002);
        cyc(1'b0, 1'b1, 1'b0);
        check("basic_empty", {61'h0, bus.fifo_cnt}, 64'h0);
    endtask

    initial begin
        cnt                = 2'd0;
        pos_base           = 16'h0;
        neg_base           = 16'h0;
        bus.pad_pos_cnt    = 2'd0;
        bus.pad_data_valid = 1'b0;
        bus.cap_en         = 1'b0;
        bus.dq_pos         = 16'h0;
        bus.dq_neg         = 16'h0;
        bus.fifo_clr       = 1'b0;
        bus.rd_ready       = 1'b0;
        arst_l             = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {63'h0, bus.rd_valid}, 64'h0);
        check("rst_cnt", {61'h0, bus.fifo_cnt}, 64'h0);
        check("rst_ovf", {63'h0, bus.ovf}, 64'h0);
        arst_l = 1'b1;

        // single burst
        run_basic();
        check("model_log_size", 64'(mlog.size()), 64'h2);
        if (mlog.size() >= 2) begin
            check("model_log0", mlog[0], 64'h2001_1001_2000_1000);
            check("model_log1", mlog[1], 64'h2003_1003_2002_1002);
        end

        // back-pressure and overflow
        pos_base = 16'hA000; neg_base = 16'hB000; burst(1'b0);
        pos_base = 16'hA100; neg_base = 16'hB100; burst(1'b0);
        pos_base = 16'hA200; neg_base = 16'hB200; burst(1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("ovf_cnt_sat", {61'h0, bus.fifo_cnt}, 64'h4);
        check("ovf_set", {63'h0, bus.ovf}, 64'h1);
        cyc(1'b0, 1'b1, 1'b0); check("drain0", bus.rd_data, 64'hB001_A001_B000_A000);
        cyc(1'b0, 1'b1, 1'b0); check("drain1", bus.rd_data, 64'hB003_A003_B002_A002);
        cyc(1'b0, 1'b1, 1'b0); check("drain2", bus.rd_data, 64'hB101_A101_B100_A100);
        cyc(1'b0, 1'b1, 1'b0); check("drain3", bus.rd_data, 64'hB103_A103_B102_A102);
        cyc(1'b0, 1'b1, 1'b0);
        check("drain_empty", {63'h0, bus.rd_valid}, 64'h0);
        check("ovf_sticky", {63'h0, bus.ovf}, 64'h1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("ovf_cleared", {63'h0, bus.ovf}, 64'h0);

        // push and pop together at full
        pos_base = 16'hC000; neg_base = 16'hD000; burst(1'b0);
        pos_base = 16'hC100; neg_base = 16'hD100; burst(1'b0);
        pos_base = 16'hC200; neg_base = 16'hD200;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("full_before", {61'h0, bus.fifo_cnt}, 64'h4);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("full_pp_cnt", {61'h0, bus.fifo_cnt}, 64'h4);
        check("full_pp_ovf", {63'h0, bus.ovf}, 64'h0);
        check("full_pp_head", bus.rd_data, 64'hD003_C003_D002_C002);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check("full_pp_cnt2", {61'h0, bus.fifo_cnt}, 64'h4);
        check("full_pp_d0", bus.rd_data, 64'hD101_C101_D100_C100);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0); check("full_pp_d2", bus.rd_data, 64'hD201_C201_D200_C200);
        cyc(1'b0, 1'b1, 1'b0); check("full_pp_d3", bus.rd_data, 64'hD203_C203_D202_C202);
        cyc(1'b0, 1'b1, 1'b0);
        check("full_pp_empty", {63'h0, bus.rd_valid}, 64'h0);
        check("full_pp_noovf", {63'h0, bus.ovf}, 64'h0);

        // flush beats a same-cycle push
        pos_base = 16'hE000; neg_base = 16'hF000; burst(1'b0);
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        check("clr_pre_cnt", {61'h0, bus.fifo_cnt}, 64'h3);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("clr_cnt", {61'h0, bus.fifo_cnt}, 64'h0);
        check("clr_valid", {63'h0, bus.rd_valid}, 64'h0);
        check("clr_ovf", {63'h0, bus.ovf}, 64'h0);

        // capture disabled: data-valid pulses must not push
        repeat (8) cyc(1'b0, 1'b0, 1'b0);
        check("noncap_cnt", {61'h0, bus.fifo_cnt}, 64'h0);

        // asynchronous reset mid-burst
        pos_base = 16'h5000; neg_base = 16'h6000; burst(1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        check("arst_pre_cnt", {61'h0, bus.fifo_cnt}, 64'h2);
        #2;
        arst_l = 1'b0;
        #1;
        check("arst_valid", {63'h0, bus.rd_valid}, 64'h0);
        check("arst_cnt", {61'h0, bus.fifo_cnt}, 64'h0);
        check("arst_ovf", {63'h0, bus.ovf}, 64'h0);
        check("arst_data", bus.rd_data, 64'h0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        arst_l = 1'b1;
        run_basic();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
